// File: rtl/ls_arbiter_if.sv
// Bundle of LSU, DMA and DataMemory signals around the local-store arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface ls_arbiter_if #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned DATA_W = 128
);
   logic              lsu_req;
   logic              lsu_we;
   logic [ADDR_W-1:0] lsu_addr;
   logic [DATA_W-1:0] lsu_wdata;
   logic              lsu_gnt;
   logic              lsu_rvalid;
   logic [DATA_W-1:0] lsu_rdata;

   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt;
   logic              dma_rvalid;
   logic [DATA_W-1:0] dma_rdata;
   logic              dma_done;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_write;
   logic              mem_read;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  lsu_req, lsu_we, lsu_addr, lsu_wdata,
      output lsu_gnt, lsu_rvalid, lsu_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_gnt, dma_rvalid, dma_rdata, dma_done,
      output mem_addr, mem_wdata, mem_write, mem_read,
      input  mem_rdata
   );

   modport master (
      output lsu_req, lsu_we, lsu_addr, lsu_wdata,
      input  lsu_gnt, lsu_rvalid, lsu_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_gnt, dma_rvalid, dma_rdata, dma_done,
      input  mem_addr, mem_wdata, mem_write,mem_read,
      output mem_rdata
   );
endinterface

// File: rtl/ls_arbiter.sv
// Local-store arbiter: shares single-port DataMemory between LSU and DMA line bursts,
// with a starvation counter that bounds how long the LSU can be held off.
module ls_arbiter #(
   parameter int unsigned ADDR_W     = 14,
   parameter int unsigned DATA_W     = 128,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic          clk_i,
   input logic          rst_ni,
   ls_arbiter_if.slave  bus_io
);
   localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
   localparam int unsigned LineW   = ADDR_W - 3;

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e              state_q, state_d;
   logic [2:0]          beat_q, beat_d;
   logic [LineW-1:0]    base_q, base_d;
   logic                we_q, we_d;
   logic [StarveW-1:0]  starve_q, starve_d;
   logic                lsu_rv_q, lsu_rv_d;
   logic                dma_rv_q, dma_rv_d;
   logic                done_q, done_d;

   logic                force_lsu;
   logic                lsu_gnt, dma_gnt;
   logic                dma_we_eff;
   logic [ADDR_W-1:0]   dma_mem_addr;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic                mem_write, mem_read;
   logic [2:0]          unused_dma_addr_lsb;

   assign unused_dma_addr_lsb = bus_io.dma_addr[2:0];

   // Grants are gated by reset so nothing reaches memory while reset is held.
   always_comb begin
      force_lsu    = bus_io.lsu_req && (starve_q == StarveW'(STARVE_MAX));
      lsu_gnt      = rst_ni && bus_io.lsu_req && (force_lsu || !bus_io.dma_req);
      dma_gnt      = rst_ni && bus_io.dma_req && !force_lsu;
      dma_we_eff   = (state_q == StIdle) ? bus_io.dma_we : we_q;
      dma_mem_addr = (state_q == StIdle) ? {bus_io.dma_addr[ADDR_W-1:3], 3'b000}
                                         : {base_q, beat_q};
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      if (lsu_gnt) begin
         mem_addr  = bus_io.lsu_addr;
         mem_wdata = bus_io.lsu_wdata;
         mem_write = bus_io.lsu_we;
         mem_read  = !bus_io.lsu_we;
      end else if (dma_gnt) begin
         mem_addr  = dma_mem_addr;
         mem_wdata = bus_io.dma_wdata;
         mem_write = dma_we_eff;
         mem_read  = !dma_we_eff;
      end
   end

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      base_d   = base_q;
      we_d     = we_q;
      starve_d = starve_q;
      done_d   = 1'b0;
      lsu_rv_d = lsu_gnt && !bus_io.lsu_we;
      dma_rv_d = dma_gnt && !dma_we_eff;

      if (lsu_gnt) begin
         starve_d = '0;
      end else if (bus_io.lsu_req && !force_lsu) begin
         starve_d = starve_q + StarveW'(1);
      end

      if (dma_gnt) begin
         unique case (state_q)
            StIdle: begin
               base_d  = bus_io.dma_addr[ADDR_W-1:3];
               we_d    = bus_io.dma_we;
               beat_d  = 3'd1;
               state_d = StBurst;
            end
            StBurst: begin
               beat_d = beat_q + 3'd1;
               if (beat_q == 3'd7) begin
                  state_d = StIdle;
                  beat_d  = 3'd0;
                  done_d  = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         beat_q   <= '0;
         base_q   <= '0;
         we_q     <= 1'b0;
         starve_q <= '0;
         lsu_rv_q <= 1'b0;
         dma_rv_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         base_q   <= base_d;
         we_q     <= we_d;
         starve_q <= starve_d;
         lsu_rv_q <= lsu_rv_d;
         dma_rv_q <= dma_rv_d;
         done_q   <= done_d;
      end
   end

   assign bus_io.lsu_gnt    = lsu_gnt;
   assign bus_io.dma_gnt    = dma_gnt;
   assign bus_io.mem_addr   = mem_addr;
   assign bus_io.mem_wdata  = mem_wdata;
   assign bus_io.mem_write  = mem_write;
   assign bus_io.mem_read   = mem_read;
   assign bus_io.lsu_rvalid = lsu_rv_q;
   assign bus_io.dma_rvalid = dma_rv_q;
   assign bus_io.lsu_rdata  = bus_io.mem_rdata;
   assign bus_io.dma_rdata  = bus_io.mem_rdata;
   assign bus_io.dma_done   = done_q;
endmodule

// File: tb/tb_ls_arbiter.sv
// Bench for ls_arbiter: DataMemory model, cycle-level reference model and directed scenarios.
module tb_ls_arbiter;
   localparam int unsigned AW = 14;
   localparam int unsigned DW = 128;
   localparam int unsigned SM = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ls_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ls_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_io (bus)
   );

   int n_chk = 0;
   int n_fail = 0;

   function automatic logic [DW-1:0] pat(input int a);
      return {4{32'hC0DE_0000 | 32'(a)}};
   endfunction

   function automatic logic [DW-1:0] dval(input int i);
      return {4{32'hDA7A_0000 + 32'(i)}};
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // DataMemory: unwritten words read back as pat(addr)
   logic [DW-1:0] dm [int];
   logic [DW-1:0] rd_q;
   always @(posedge clk) begin
      if (bus.mem_read)
         rd_q <= dm.exists(int'(bus.mem_addr)) ? dm[int'(bus.mem_addr)] : pat(int'(bus.mem_addr));
      if (bus.mem_write) dm[int'(bus.mem_addr)] = bus.mem_wdata;
   end
   assign bus.mem_rdata = rd_q;

   // Reference model: beats done in the current line, line number, LSU wait count
   int            m_beats, m_line, m_wait;
   bit            m_wr;
   bit            e_lrv, e_drv, e_done;
   logic [DW-1:0] e_rd;
   logic [DW-1:0] mm [int];

   always @(negedge clk) begin : cmp
      bit            lg, dg, we;
      int            a;
      logic [DW-1:0] wd;
      if (!rst_n) begin
         chk("rst lsu_gnt", bus.lsu_gnt, 0);
         chk("rst dma_gnt", bus.dma_gnt, 0);
         chk("rst mem_write", bus.mem_write, 0);
         chk("rst mem_read", bus.mem_read, 0);
         chk("rst lsu_rvalid", bus.lsu_rvalid, 0);
         chk("rst dma_rvalid", bus.dma_rvalid, 0);
         chk("rst dma_done", bus.dma_done, 0);
         m_beats = 0; m_line = 0; m_wait = 0; m_wr = 0;
         e_lrv = 0; e_drv = 0; e_done = 0; e_rd = '0;
      end else begin
         chk("lsu_rvalid", bus.lsu_rvalid, e_lrv);
         chk("dma_rvalid", bus.dma_rvalid, e_drv);
         chk("dma_done", bus.dma_done, e_done);
         if (e_lrv) chk("lsu_rdata", bus.lsu_rdata, e_rd);
         if (e_drv) chk("dma_rdata", bus.dma_rdata, e_rd);

         lg = bus.lsu_req && (m_wait >= int'(SM) || !bus.dma_req);
         dg = bus.dma_req && !lg;
         a = 0; we = 0; wd = '0;
         if (lg) begin
            a = int'(bus.lsu_addr); we = bus.lsu_we; wd = bus.lsu_wdata;
         end else if (dg) begin
            a  = (m_beats == 0) ? (int'(bus.dma_addr) & ~7) : m_line * 8 + m_beats;
            we = (m_beats == 0) ? bus.dma_we : m_wr;
            wd = bus.dma_wdata;
         end
         chk("lsu_gnt", bus.lsu_gnt, lg);
         chk("dma_gnt", bus.dma_gnt, dg);
         chk("mem_write", bus.mem_write, (lg || dg) && we);
         chk("mem_read", bus.mem_read, (lg || dg) && !we);
         chk("mem_addr", bus.mem_addr, a);
         chk("mem_wdata", bus.mem_wdata, wd);

         e_lrv  = lg && !we;
         e_drv  = dg && !we;
         e_done = 0;
         e_rd   = mm.exists(a) ? mm[a] : pat(a);
         if ((lg || dg) && we) mm[a] = wd;
         if (lg) m_wait = 0;
         else if (bus.lsu_req && m_wait < int'(SM)) m_wait++;
         if (dg) begin
            if (m_beats == 0) begin
               m_line = int'(bus.dma_addr) >> 3;
               m_wr   = bus.dma_we;
            end
            m_beats++;
            if (m_beats == 8) begin
               m_beats = 0;
               e_done  = 1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic lsu_read_check(input int a, input logic [DW-1:0] exp, input string nm);
      step();
      bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_addr = AW'(a);
      @(negedge clk);
      step();
      bus.lsu_req = 0;
      @(negedge clk);
      chk(nm, bus.lsu_rdata, exp);
   endtask

   initial begin
      bus.lsu_req = 0; bus.lsu_we = 0; bus.lsu_addr = '0; bus.lsu_wdata = '0;
      bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;

      // Reset held with both requests high
      bus.lsu_req = 1; bus.dma_req = 1; bus.dma_addr = 14'h0300;
      repeat (3) begin
         @(negedge clk);
         chk("reset lsu_gnt", bus.lsu_gnt, 0);
         chk("reset dma_gnt", bus.dma_gnt, 0);
      end
      step();
      rst_n = 1; bus.lsu_req = 0;
      @(negedge clk);
      chk("first beat gnt", bus.dma_gnt, 1);
      chk("first beat addr", bus.mem_addr, 14'h0300);
      repeat (7) begin
         step();
         @(negedge clk);
      end
      step();
      bus.dma_req = 0;
      @(negedge clk);
      chk("read burst done", bus.dma_done, 1);

      // LSU read with DMA idle
      step();
      bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_addr = 14'h0010;
      @(negedge clk);
      chk("lsu rd gnt", bus.lsu_gnt, 1);
      chk("lsu rd strobe", bus.mem_read, 1);
      chk("lsu rd addr", bus.mem_addr, 14'h0010);
      step();
      bus.lsu_req = 0;
      @(negedge clk);
      chk("lsu rvalid", bus.lsu_rvalid, 1);
      chk("lsu rdata", bus.lsu_rdata, pat(16'h0010));

      // DMA write burst; address/direction changes after the first beat must be ignored
      for (int i = 0; i < 8; i++) begin
         step();
         bus.dma_req = 1;
         bus.dma_we = (i == 0);
         bus.dma_addr = (i == 0) ? 14'h0105 : 14'h3FF0;
         bus.dma_wdata = dval(i);
         @(negedge clk);
         chk("wr burst addr", bus.mem_addr, 14'h0100 + 14'(i));
         chk("wr burst strobe", bus.mem_write, 1);
         chk("wr burst no done", bus.dma_done, 0);
      end
      step();
      bus.dma_req = 0;
      @(negedge clk);
      chk("wr burst done", bus.dma_done, 1);
      step();
      @(negedge clk);
      chk("done is one pulse", bus.dma_done, 0);
      lsu_read_check(16'h0100, dval(0), "mem D0");
      lsu_read_check(16'h0107, dval(7), "mem D7");

      // Starvation: two back-to-back DMA read bursts, LSU write raised at cycle 2
      for (int c = 0; c < 18; c++) begin
         step();
         bus.dma_req = (c < 17); bus.dma_we = 0; bus.dma_addr = 14'h0400;
         bus.lsu_req = (c >= 2 && c <= 6); bus.lsu_we = 1;
         bus.lsu_addr = 14'h0020; bus.lsu_wdata = dval(99);
         @(negedge clk);
         if (c == 5) chk("starve still waiting", bus.lsu_gnt, 0);
         if (c == 6) begin
            chk("starve forced gnt", bus.lsu_gnt, 1);
            chk("starve dma stalled", bus.dma_gnt, 0);
         end
         if (c == 7) chk("starve no skip", bus.mem_addr, 14'h0406);
         if (c == 8) chk("starve done late", bus.dma_done, 0);
         if (c == 9) begin
            chk("starve done", bus.dma_done, 1);
            chk("b2b first beat", bus.dma_gnt, 1);
         end
         if (c == 17) chk("second burst done", bus.dma_done, 1);
      end
      lsu_read_check(16'h0020, dval(99), "forced write data");

      // Gap fill: DMA drops for one cycle mid-burst
      for (int c = 0; c < 9; c++) begin
         step();
         bus.dma_req = (c != 3); bus.dma_we = 1; bus.dma_addr = 14'h0605;
         bus.dma_wdata = dval(16 + c);
         bus.lsu_req = (c == 3); bus.lsu_we = 0; bus.lsu_addr = 14'h0603;
         @(negedge clk);
         if (c == 3) chk("gap fill gnt", bus.lsu_gnt, 1);
         if (c == 4) begin
            chk("gap resume addr", bus.mem_addr, 14'h0603);
            chk("gap rdata", bus.lsu_rdata, pat(16'h0603));
         end
      end
      step();
      bus.dma_req = 0;
      @(negedge clk);
      chk("gap burst done", bus.dma_done, 1);

      // Reset after beat 3 of a write burst, then a fresh read burst at 0x0200
      for (int c = 0; c < 4; c++) begin
         step();
         bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 14'h0705; bus.dma_wdata = dval(32 + c);
         @(negedge clk);
      end
      step();
      rst_n = 0;
      @(negedge clk);
      chk("midrst dma_gnt", bus.dma_gnt, 0);
      step();
      @(negedge clk);
      step();
      rst_n = 1; bus.dma_we = 0; bus.dma_addr = 14'h0200;
      @(negedge clk);
      chk("restart gnt", bus.dma_gnt, 1);
      chk("restart addr", bus.mem_addr, 14'h0200);
      for (int c = 1; c < 8; c++) begin
         step();
         bus.dma_addr = 14'h03F8;
         @(negedge clk);
         chk("no stale done", bus.dma_done, 0);
      end
      step();
      bus.dma_req = 0;
      @(negedge clk);
      chk("restart done", bus.dma_done, 1);
      lsu_read_check(16'h0703, dval(35), "pre-reset beat kept");

      step();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ls_arbiter.md
# ls_arbiter

Arbiter and sequencer for the single-port 128-bit DataMemory (local store), shared between the Memory stage load/store path (LSU) and the DMA engine. It sits between the pipeline Memory stage and DataMemory and multiplexes the address, write data and read/write strobes. It sequences 8-quadword DMA line bursts and enforces a bounded-wait guarantee for the pipeline.

## Interface

- ADDR_W, 14, quadword address width (256 KB local store)
- DATA_W, 128, data width
- STARVE_MAX, 4, consecutive LSU-blocked cycles before LSU forces priority (≥1)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- lsu_req  in  1  LSU access request
- lsu_we  in  1  1 = write, 0 = read
- lsu_addr  in  ADDR_W  LSU quadword address
- lsu_wdata  in  DATA_W  LSU write data
- lsu_gnt  out  1  LSU access performed this cycle
- lsu_rvalid  out  1  LSU read data valid
- lsu_rdata  out  DATA_W  LSU read data
- dma_req  in  1  DMA beat request
- dma_we  in  1  1 = write burst, 0 = read burst; sampled on first beat
- dma_addr  in  ADDR_W  line address, sampled on first beat only
- dma_wdata  in  DATA_W  write data for the current beat
- dma_gnt  out  1  DMA beat performed this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  DATA_W  DMA read data
- dma_done  out  1  one-cycle pulse after the 8th beat
- mem_addr  out  ADDR_W  to DataMemory
- mem_wdata  out  DATA_W  to DataMemory
- mem_write  out  1  to DataMemory
- mem_read  out  1  to DataMemory
- mem_rdata  in  DATA_W  from DataMemory; valid the cycle after mem_read

## Operation

- **States:**
  - IDLE: no burst open.
  - BURST: DMA line in progress. Tracks beat counter `beat` (3 bits), latched base address, and latched direction.
- **Handshake:**
  - A requester holds req and its fields stable until gnt.
  - Transfer occurs in any cycle with req && gnt.
  - At most one gnt is high per cycle.
  - gnt is combinational from req and the registered state.
- **Starvation counter `starve`:**
  - Increments, saturating at STARVE_MAX, each cycle lsu_req && !lsu_gnt.
  - Clears on lsu_gnt.
  - `force` = lsu_req && starve == STARVE_MAX.
- **Grant rules:**
  - IDLE: `force` grants LSU. Otherwise dma_req grants DMA. Otherwise lsu_req grants LSU.
  - BURST: `force` grants LSU and the DMA beat stalls. Otherwise dma_req grants DMA. Otherwise lsu_req grants LSU (gap fill).
- **DMA addressing:**
  - First beat (IDLE): mem_addr = {dma_addr[ADDR_W-1:3], 3'b000}. Latch base and dma_we. Set beat = 1. Go to BURST.
  - Subsequent beats: mem_addr = {base[ADDR_W-1:3], beat}.
  - dma_addr[2:0] and dma_addr/dma_we after the first beat are ignored.
  - beat increments only on dma_gnt.
  - On the granted beat with beat == 7, return to IDLE and set beat to 0.
- **Memory signals:**
  - mem_write = gnt && we of the granted source. mem_read = gnt && !we.
  - mem_wdata is taken from the granted source.
  - With no grant, all strobes are 0 and mem_addr/mem_wdata hold 0.
- **Read return:**
  - A registered tag records the source of a granted read.
  - xx_rvalid is high the following cycle.
  - lsu_rdata and dma_rdata = mem_rdata, unqualified; consumers use rvalid.
- **dma_done:** registered; high the cycle after the 8th beat's grant.

## Timing

- **Reset (reset low, asynchronous):**
  - State IDLE; beat, starve and the rvalid tag are 0.
  - dma_done, lsu_rvalid and dma_rvalid are 0.
  - lsu_gnt, dma_gnt, mem_write and mem_read are forced to 0 while reset is low.
- **Reset mid-burst:** the burst is abandoned. After release the DMA must restart from its first beat.
- **Latency:**
  - Grant: 0 cycles when uncontended.
  - Write: committed at the clock edge ending the grant cycle.
  - Read: data returned 1 cycle after the grant.
- **Worst-case LSU wait:** STARVE_MAX cycles from first lsu_req.
- **Back-to-back:** a new DMA first beat may be granted the cycle after the previous 8th beat. dma_done and the next grant may coincide.
- **Simultaneous events:**
  - lsu_req and dma_req both high with `force` high: LSU wins, dma_gnt = 0, beat unchanged.
  - Forced LSU grant at beat 7: the 8th beat is delayed and dma_done follows its actual grant.
- **Throughput:** a continuous DMA stream with no LSU traffic completes 8 beats in 8 cycles.

## Test plan

- **Reset values:** reset low with both requests high → all gnt, strobes, rvalid and dma_done are 0. Release → IDLE, and a DMA first beat is granted.
- **LSU read:** lsu_req=1, lsu_we=0, lsu_addr=0x0010, DMA idle → lsu_gnt same cycle, mem_read=1, mem_addr=0x0010. Next cycle lsu_rvalid=1 and lsu_rdata equals the preloaded word.
- **DMA write burst:** dma_addr=0x0105, dma_we=1, dma_req held for 8 cycles with data D0..D7 → mem_addr steps 0x0100..0x0107 with mem_write=1 each cycle. dma_done pulses once in cycle 9. Memory holds D0..D7.
- **Starvation:** STARVE_MAX=4, DMA streaming two bursts, lsu_req raised at cycle 2 → lsu_gnt in cycle 6. The DMA beat stalls one cycle without an address skip. dma_done is delayed by 1.
- **Gap fill:** dma_req drops for 1 cycle mid-burst while lsu_req=1 → LSU is granted that cycle. The DMA resumes at the same beat address.
- **Reset mid-burst:** reset after beat 3 → after release state is IDLE. A new dma_addr=0x0200 burst starts at 0x0200 with no dma_done from the aborted burst.
